// File: rtl/jtsdram_arb_if.sv
// Requester-side bus of the four-port SDRAM arbiter.
//   req[n]  : request level, held until ack[n]
//   we[n]   : 1 = write, 0 = read, valid with req[n]
//   addr[n] : {row[12:0], col[8:0]}, valid with req[n]
//   din[n]  : write data, valid with req[n]
//   ack[n]  : one-cycle grant pulse
//   rdy[n]  : one-cycle completion pulse; read data valid on dout
//   dout    : read data shared by all requesters
// master = requester side, slave = arbiter side.
interface jtsdram_arb_if;
  logic [3:0]       req;
  logic [3:0]       we;
  logic [3:0][21:0] addr;
  logic [3:0][15:0] din;
  logic [3:0]       ack;
  logic [3:0]       rdy;
  logic [15:0]      dout;

  modport master (output req, we, addr, din, input ack, rdy, dout);
  modport slave  (input req, we, addr, din, output ack, rdy, dout);
endinterface

// File: rtl/jtsdram_arb.sv
// Four-port round-robin SDRAM arbiter with periodic auto refresh.
// Each granted access is a single-word ACTIVE -> READ/WRITE with auto-precharge.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   init_done     : SDRAM power-up init finished; no commands issued while low
//   bus           : requester handshake bus (jtsdram_arb_if.slave)
//   sdram_cmd     : {cs_n, ras_n, cas_n, we_n}
//   sdram_ba/a    : bank / address, hold their last value between commands
//   sdram_dq_out  : write data, driven with sdram_dq_oe in the WRITE cycle only
//   sdram_dq      : read data from the device
// All SDRAM and handshake outputs are registered.
module jtsdram_arb #(
  parameter int unsigned CL     = 2,
  parameter int unsigned TRCD   = 2,
  parameter int unsigned TRP    = 2,
  parameter int unsigned TRFC   = 7,
  parameter int unsigned REFCNT = 780
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_done,
  jtsdram_arb_if.slave       bus,
  output logic [3:0]         sdram_cmd,
  output logic [1:0]         sdram_ba,
  output logic [12:0]        sdram_a,
  output logic [15:0]        sdram_dq_out,
  output logic               sdram_dq_oe,
  input  logic [15:0]        sdram_dq
);

  localparam int unsigned CntW = 8;
  localparam int unsigned RefW = $clog2(REFCNT + 1);

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdRef = 4'b0001;

  // The state register tracks the cycle in which the registered command is
  // visible: RW is the READ/WRITE cycle, REF starts with the AUTO REFRESH cycle.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRcd  = 3'd1;
  localparam logic [2:0] StRw   = 3'd2;
  localparam logic [2:0] StClw  = 3'd3;
  localparam logic [2:0] StPre  = 3'd4;
  localparam logic [2:0] StRef  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic            we_q, we_d;
  logic [8:0]      col_q, col_d;
  logic [15:0]     din_q, din_d;
  logic            rd_done_q, rd_done_d;
  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic            ref_pend_q, ref_pend_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [1:0]      ba_q, ba_d;
  logic [12:0]     a_q, a_d;
  logic [15:0]     dq_out_q, dq_out_d;
  logic            dq_oe_q, dq_oe_d;
  logic [3:0]      ack_q, ack_d;
  logic [3:0]      rdy_q, rdy_d;
  logic [15:0]     dout_q, dout_d;

  logic            gnt_valid;
  logic [1:0]      gnt_idx;
  logic            ref_exp;

  // Round robin: search starts at last granted + 1 and wraps back to last granted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!gnt_valid && bus.req[2'(last_q + 2'(i))]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'(last_q + 2'(i));
      end
    end
  end

  // Free-running refresh interval counter, runs regardless of FSM state.
  always_comb begin
    ref_exp   = (ref_cnt_q == RefW'(REFCNT - 1));
    ref_cnt_d = ref_exp ? '0 : ref_cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    we_d       = we_q;
    col_d      = col_q;
    din_d      = din_q;
    rd_done_d  = 1'b0;
    ref_pend_d = ref_pend_q;
    cmd_d      = CmdNop;
    ba_d       = ba_q;
    a_d        = a_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    ack_d      = 4'b0000;
    rdy_d      = 4'b0000;
    dout_d     = dout_q;

    // Read completion is reported one cycle after dout captured the data.
    if (rd_done_q) rdy_d[last_q] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (init_done) begin
          if (ref_pend_q) begin
            cmd_d      = CmdRef;
            ref_pend_d = 1'b0;
            state_d    = StRef;
            cnt_d      = CntW'(TRFC - 2);
          end else if (gnt_valid) begin
            cmd_d          = CmdAct;
            ba_d           = gnt_idx;
            a_d            = bus.addr[gnt_idx][21:9];
            ack_d[gnt_idx] = 1'b1;
            last_d         = gnt_idx;
            we_d           = bus.we[gnt_idx];
            col_d          = bus.addr[gnt_idx][8:0];
            din_d          = bus.din[gnt_idx];
            state_d        = StRcd;
            cnt_d          = CntW'(TRCD - 1);
          end
        end
      end
      StRcd: begin
        if (cnt_q == '0) begin
          cmd_d   = we_q ? CmdWr : CmdRd;
          // A10 set selects auto-precharge.
          a_d     = {2'b00, 1'b1, 1'b0, col_q};
          state_d = StRw;
          if (we_q) begin
            dq_oe_d       = 1'b1;
            dq_out_d      = din_q;
            rdy_d[last_q] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRw: begin
        if (we_q) begin
          state_d = StPre;
          cnt_d   = CntW'(TRP - 1);
        end else begin
          state_d = StClw;
          cnt_d   = CntW'(CL - 2);
        end
      end
      StClw: begin
        if (cnt_q == '0) begin
          // This edge is the CL-th rising edge after the READ edge.
          dout_d    = sdram_dq;
          rd_done_d = 1'b1;
          state_d   = StPre;
          cnt_d     = CntW'(TRP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPre, StRef: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Expiry while already pending simply keeps the single pending flag set.
    if (ref_exp) ref_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= 2'd3;
      we_q       <= 1'b0;
      col_q      <= '0;
      din_q      <= '0;
      rd_done_q  <= 1'b0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      cmd_q      <= CmdNop;
      ba_q       <= '0;
      a_q        <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      ack_q      <= '0;
      rdy_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      col_q      <= col_d;
      din_q      <= din_d;
      rd_done_q  <= rd_done_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      dout_q     <= dout_d;
    end
  end

  assign sdram_cmd    = cmd_q;
  assign sdram_ba     = ba_q;
  assign sdram_a      = a_q;
  assign sdram_dq_out = dq_out_q;
  assign sdram_dq_oe  = dq_oe_q;
  assign bus.ack      = ack_q;
  assign bus.rdy      = rdy_q;
  assign bus.dout     = dout_q;

endmodule

// File: tb/tb_jtsdram_arb.sv
// Directed self-checking bench for jtsdram_arb (default timing parameters).
module tb_jtsdram_arb;
  localparam int unsigned CL = 2, TRCD = 2, TRP = 2, TRFC = 7, REFCNT = 780;
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdRef = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic [15:0] sdram_dq = 16'h1111;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int checks = 0;
  int passed = 0;
  int unsigned cyc;

  jtsdram_arb_if bus ();

  jtsdram_arb #(
    .CL(CL), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .REFCNT(REFCNT)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .bus(bus),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .sdram_dq(sdram_dq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tracks the DUT refresh counter.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.req = 4'b0;
    bus.we  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      bus.addr[i] = 22'h0;
      bus.din[i]  = 16'h0;
    end
  endtask

  task automatic do_reset(input logic init);
    tick();
    rst = 1'b1;
    clear_reqs();
    init_done = init;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    tick();
    tick();
    checks++; if (sdram_cmd !== CmdNop) $display("FAIL rst_cmd: got %b want %b", sdram_cmd, CmdNop);
    else passed++;
    checks++; if (bus.ack !== 4'b0 || bus.rdy !== 4'b0)
      $display("FAIL rst_ackrdy: got ack=%b rdy=%b want 0000/0000", bus.ack, bus.rdy);
    else passed++;
    checks++; if (sdram_dq_oe !== 1'b0 || bus.dout !== 16'h0)
      $display("FAIL rst_oe_dout: got oe=%b dout=%h want 0/0000", sdram_dq_oe, bus.dout);
    else passed++;
    checks++; if (sdram_ba !== 2'd0 || sdram_a !== 13'h0)
      $display("FAIL rst_ba_a: got ba=%0d a=%h want 0/0000", sdram_ba, sdram_a);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_read();
    do_reset(1'b1);
    bus.we[0] = 1'b0; bus.addr[0] = {13'h0123, 9'h045}; bus.req[0] = 1'b1;
    tick();  // t
    checks++; if (sdram_cmd !== CmdAct || sdram_ba !== 2'd0 || sdram_a !== 13'h0123)
      $display("FAIL rd_act: got cmd=%b ba=%0d a=%h want %b/0/0123", sdram_cmd, sdram_ba,
               sdram_a, CmdAct);
    else passed++;
    checks++; if (bus.ack !== 4'b0001) $display("FAIL rd_ack: got %b want 0001", bus.ack);
    else passed++;
    bus.req[0] = 1'b0;
    tick();  // t+1
    checks++; if (sdram_cmd !== CmdNop) $display("FAIL rd_rcd_nop: got %b want %b", sdram_cmd, CmdNop);
    else passed++;
    tick();  // t+2
    checks++; if (sdram_cmd !== CmdRd || sdram_a !== 13'h0445 || sdram_ba !== 2'd0)
      $display("FAIL rd_read: got cmd=%b a=%h ba=%0d want %b/0445/0", sdram_cmd, sdram_a,
               sdram_ba, CmdRd);
    else passed++;
    tick();  // t+3
    sdram_dq = 16'hBEEF;
    checks++; if (sdram_cmd !== CmdNop || sdram_a !== 13'h0445)
      $display("FAIL rd_hold_a: got cmd=%b a=%h want %b/0445", sdram_cmd, sdram_a, CmdNop);
    else passed++;
    tick();  // t+4
    sdram_dq = 16'h2222;
    checks++; if (bus.rdy !== 4'b0) $display("FAIL rd_rdy_early: got %b want 0000", bus.rdy);
    else passed++;
    tick();  // t+5
    checks++; if (bus.rdy !== 4'b0001 || bus.dout !== 16'hBEEF)
      $display("FAIL rd_rdy_dout: got rdy=%b dout=%h want 0001/beef", bus.rdy, bus.dout);
    else passed++;
    tick();  // t+6
    checks++; if (bus.rdy !== 4'b0) $display("FAIL rd_rdy_pulse: got %b want 0000", bus.rdy);
    else passed++;
  endtask

  task automatic test_write();
    bus.we[2] = 1'b1; bus.addr[2] = {13'h1ABC, 9'h1FF}; bus.din[2] = 16'hAAAA;
    bus.req[2] = 1'b1;
    tick();
    for (int i = 0; i < 20 && bus.ack[2] !== 1'b1; i++) tick();
    checks++; if (bus.ack !== 4'b0100 || sdram_cmd !== CmdAct || sdram_ba !== 2'd2 ||
                  sdram_a !== 13'h1ABC)
      $display("FAIL wr_act: got ack=%b cmd=%b ba=%0d a=%h want 0100/%b/2/1abc", bus.ack,
               sdram_cmd, sdram_ba, sdram_a, CmdAct);
    else passed++;
    bus.req[2] = 1'b0;
    tick();  // t+1
    checks++; if (sdram_dq_oe !== 1'b0) $display("FAIL wr_oe_early: got %b want 0", sdram_dq_oe);
    else passed++;
    tick();  // t+2
    checks++; if (sdram_cmd !== CmdWr || sdram_a !== 13'h05FF || sdram_ba !== 2'd2)
      $display("FAIL wr_cmd: got cmd=%b a=%h ba=%0d want %b/05ff/2", sdram_cmd, sdram_a,
               sdram_ba, CmdWr);
    else passed++;
    checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 16'hAAAA || bus.rdy !== 4'b0100)
      $display("FAIL wr_data: got oe=%b dq=%h rdy=%b want 1/aaaa/0100", sdram_dq_oe,
               sdram_dq_out, bus.rdy);
    else passed++;
    tick();  // t+3
    checks++; if (sdram_dq_oe !== 1'b0 || bus.rdy !== 4'b0)
      $display("FAIL wr_after: got oe=%b rdy=%b want 0/0000", sdram_dq_oe, bus.rdy);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_round_robin();
    int n;
    int ba_seen [5];
    int at [5];
    logic [3:0] ack_seen [5];
    int exp_ba [5];
    exp_ba = '{0, 1, 2, 3, 0};
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.we[i] = 1'b1; bus.addr[i] = 22'(i * 1000); bus.din[i] = 16'(i); bus.req[i] = 1'b1;
    end
    n = 0;
    for (int i = 0; i < 150 && n < 5; i++) begin
      tick();
      if (sdram_cmd === CmdAct) begin
        ba_seen[n] = int'(sdram_ba); at[n] = i; ack_seen[n] = bus.ack; n++;
      end
    end
    checks++; if (n != 5) $display("FAIL rr_count: got %0d want 5", n);
    else passed++;
    for (int k = 0; k < n; k++) begin
      checks++; if (ba_seen[k] != exp_ba[k] || ack_seen[k] !== 4'(1 << exp_ba[k]))
        $display("FAIL rr_order%0d: got ba=%0d ack=%b want ba=%0d", k, ba_seen[k],
                 ack_seen[k], exp_ba[k]);
      else passed++;
      if (k > 0) begin
        checks++; if (at[k] - at[k-1] < int'(TRCD + 1 + TRP))
          $display("FAIL rr_gap%0d: got %0d want >= %0d", k, at[k] - at[k-1], TRCD + 1 + TRP);
        else passed++;
      end
    end
    clear_reqs();
    repeat (10) tick();
  endtask

  task automatic test_refresh_during_read();
    int g;
    do_reset(1'b1);
    for (int i = 0; i < 1000 && cyc != 775; i++) tick();
    bus.we[1] = 1'b0; bus.addr[1] = {13'h0042, 9'h011}; bus.req[1] = 1'b1;
    bus.we[3] = 1'b1; bus.addr[3] = {13'h0777, 9'h022}; bus.din[3] = 16'h5A5A;
    bus.req[3] = 1'b1;
    tick();
    checks++; if (sdram_cmd !== CmdAct || bus.ack !== 4'b0010)
      $display("FAIL ref_ba1_act: got cmd=%b ack=%b want %b/0010", sdram_cmd, bus.ack, CmdAct);
    else passed++;
    bus.req[1] = 1'b0;
    for (int i = 0; i < 20 && bus.rdy[1] !== 1'b1; i++) tick();
    checks++; if (bus.rdy[1] !== 1'b1) $display("FAIL ref_ba1_rdy: got 0 want 1");
    else passed++;
    tick();
    for (int i = 0; i < 20 && sdram_cmd === CmdNop; i++) tick();
    checks++; if (sdram_cmd !== CmdRef)
      $display("FAIL ref_first: got %b want %b", sdram_cmd, CmdRef);
    else passed++;
    g = 0;
    do begin tick(); g++; end while (sdram_cmd === CmdNop && g < 20);
    checks++; if (sdram_cmd !== CmdAct || sdram_ba !== 2'd3 || bus.ack !== 4'b1000 ||
                  g != int'(TRFC))
      $display("FAIL ref_ba3_act: got cmd=%b ba=%0d ack=%b gap=%0d want %b/3/1000/%0d",
               sdram_cmd, sdram_ba, bus.ack, g, CmdAct, TRFC);
    else passed++;
    clear_reqs();
    repeat (10) tick();
  endtask

  task automatic test_reset_in_clw();
    int bad;
    do_reset(1'b1);
    bus.we[0] = 1'b0; bus.addr[0] = {13'h0100, 9'h003}; bus.req[0] = 1'b1;
    tick();  // t
    checks++; if (bus.ack !== 4'b0001) $display("FAIL clw_ack: got %b want 0001", bus.ack);
    else passed++;
    bus.req[0] = 1'b0;
    repeat (3) tick();  // t+3, in CLW
    rst = 1'b1;
    #1;
    checks++; if (sdram_cmd !== CmdNop || bus.rdy !== 4'b0)
      $display("FAIL clw_rst: got cmd=%b rdy=%b want %b/0000", sdram_cmd, bus.rdy, CmdNop);
    else passed++;
    bus.req[0] = 1'b1;
    bad = 0;
    repeat (3) begin tick(); if (bus.rdy !== 4'b0) bad++; end
    rst = 1'b0;
    tick();
    if (bus.rdy !== 4'b0) bad++;
    checks++; if (bad != 0) $display("FAIL clw_no_rdy: got %0d rdy cycles want 0", bad);
    else passed++;
    checks++; if (sdram_cmd !== CmdAct || sdram_ba !== 2'd0 || bus.ack !== 4'b0001)
      $display("FAIL clw_reack: got cmd=%b ba=%0d ack=%b want %b/0/0001", sdram_cmd, sdram_ba,
               bus.ack, CmdAct);
    else passed++;
    bus.req[0] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_init_hold();
    int bad;
    int g;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.we[i] = 1'b0; bus.addr[i] = 22'(i); bus.req[i] = 1'b1;
    end
    bad = 0;
    repeat (2000) begin
      tick();
      if (sdram_cmd !== CmdNop || bus.ack !== 4'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL init_quiet: got %0d active cycles want 0", bad);
    else passed++;
    init_done = 1'b1;
    tick();
    for (int i = 0; i < 10 && sdram_cmd === CmdNop; i++) tick();
    checks++; if (sdram_cmd !== CmdRef)
      $display("FAIL init_first_ref: got %b want %b", sdram_cmd, CmdRef);
    else passed++;
    g = 0;
    do begin tick(); g++; end while (sdram_cmd === CmdNop && g < 20);
    checks++; if (sdram_cmd !== CmdAct || bus.ack !== 4'b0001 || g != int'(TRFC))
      $display("FAIL init_single_ref: got cmd=%b ack=%b gap=%0d want %b/0001/%0d",
               sdram_cmd, bus.ack, g, CmdAct, TRFC);
    else passed++;
    clear_reqs();
    repeat (10) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_reqs();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_refresh_during_read();
    test_reset_in_clw();
    test_init_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtsdram_arb.md
JTSDRAM_ARB -- requirements
Module: jtsdram_arb

Interface
REQ-001 Parameter CL, default 2: CAS latency in clocks (2 or 3).
REQ-002 Parameter TRCD, default 2: ACTIVE-to-READ/WRITE delay in clocks.
REQ-003 Parameter TRP, default 2: auto-precharge completion delay in clocks.
REQ-004 Parameter TRFC, default 7: AUTO REFRESH busy time in clocks.
REQ-005 Parameter REFCNT, default 780: refresh interval in clocks.
REQ-006 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-007 init_done  input  1  SDRAM power-up init finished; arbitration blocked while low.
REQ-008 baN_req (N=0..3)  input  1  request level, held until ack.
REQ-009 baN_we  input  1  1 = write, 0 = read; valid with req.
REQ-010 baN_addr  input  22  {row[12:0], col[8:0]}; valid with req.
REQ-011 baN_din  input  16  write data; valid with req.
REQ-012 baN_ack  output  1  one-cycle grant pulse.
REQ-013 baN_rdy  output  1  one-cycle completion pulse; read data valid on dout.
REQ-014 dout  output  16  read data, shared by all requesters.
REQ-015 sdram_cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
REQ-016 sdram_ba  output  2; sdram_a  output  13; sdram_dq_out  output  16; sdram_dq_oe  output  1; sdram_dq  input  16.

Function
REQ-017 Command codes: NOP 4'b0111, ACTIVE 4'b0011, READ 4'b0101, WRITE 4'b0100, AUTO REFRESH 4'b0001; every non-issue cycle is NOP.
REQ-018 States: IDLE, RCD, RW, CLW, PRE, REF; one command issued at most per cycle.
REQ-019 IDLE, init_done=1, refresh pending: issue AUTO REFRESH, clear pending, go REF for TRFC cycles, then IDLE.
REQ-020 IDLE, no refresh pending, any req: round-robin grant starting at last-granted+1 mod 4; issue ACTIVE with sdram_ba=N, sdram_a=row; pulse baN_ack same cycle; latch we/addr/din; go RCD.
REQ-021 RCD lasts TRCD-1 cycles (NOP), then RW: issue READ or WRITE, sdram_a={2'b00, A10=1 (auto-precharge), 1'b0, col}.
REQ-022 Write: sdram_dq_oe=1 and sdram_dq_out=din in the WRITE cycle only; baN_rdy pulses that same cycle; go PRE.
REQ-023 Read: go CLW; dout registered from sdram_dq on the CL-th rising edge after the READ edge; baN_rdy pulses in the cycle following that edge; then PRE.
REQ-024 PRE lasts TRP cycles (NOP), then IDLE; next ACTIVE no earlier than the cycle after PRE ends.
REQ-025 Refresh counter: 0..REFCNT-1, increments every cycle including while busy; at REFCNT-1 wraps to 0 and sets refresh pending; a second expiry while pending SHALL not queue a second refresh.
REQ-026 Refresh pending beats any request in IDLE; an in-flight transaction is never interrupted.
REQ-027 req still high in IDLE after its own rdy is a new request; requesters drop req the cycle after ack.
REQ-028 init_done=0: remain IDLE, issue only NOP; refresh counter still runs.
REQ-029 sdram_ba, sdram_a hold last value outside command cycles; sdram_dq_oe=0 outside WRITE cycles.

Reset
REQ-030 On rst: state IDLE, sdram_cmd=NOP, all ack/rdy=0, sdram_dq_oe=0, dout=0, sdram_ba=0, sdram_a=0, last-granted=3 (ba0 first), refresh counter 0, pending cleared.
REQ-031 rst mid-transaction: abort immediately; no rdy for the aborted request; requester re-requests.

Verification
REQ-032 ba0 read, addr row=0x0123 col=0x045, CL=2, TRCD=2 -> ACTIVE ba=0 a=0x0123 + ba0_ack at t; READ a=0x0445 at t+2; ba0_rdy at t+5 with dout = dq sampled at edge t+4.
REQ-033 ba2 write din=0xAAAA -> ACTIVE, WRITE 2 cycles later with dq_oe=1, dq_out=0xAAAA, ba2_rdy same cycle; dq_oe=0 next cycle.
REQ-034 All four req held continuously -> ack order ba0, ba1, ba2, ba3, ba0; no two ACTIVEs closer than TRCD+1+TRP cycles for writes.
REQ-035 Refresh expiry during a ba1 read -> read completes; AUTO REFRESH issued at next IDLE before pending ba3 request; ba3 ACTIVE TRFC cycles later.
REQ-036 rst asserted in CLW -> sdram_cmd=NOP, no rdy; after release with init_done=1 and ba0_req, ACTIVE for ba0 next cycle.
REQ-037 init_done=0 with all req high for 2000 cycles -> only NOP, no ack; first command after init_done rises is AUTO REFRESH.
